regfile_writeback: RTL and testbench

- Write-side master for the SIMD register file: collects result bundles (up to WRITE_PORTS_REGF register writes each) from the execute lanes.
- Buffers them in a small queue and drives the regfile's w_addr/w_data/wr_en ports at one bundle per cycle.
- Normalises each bundle so the regfile's single shared wr_en and its port write order can never corrupt a register.
- Exports per-register busy bits so issue logic can stall reads of registers with pending writes.

---
 rtl/regfile_writeback_pkg.sv | 19 +
 rtl/wb_bundle_sanitize.sv | 41 ++++
 rtl/regfile_writeback.sv | 107 ++++++++++
 tb/tb_regfile_writeback.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_writeback_pkg.sv
// Shared register-file write constants and the result bundle carried from the execute lanes.
package regfile_writeback_pkg;

    localparam int unsigned NSIG             = 15;
    localparam int unsigned ADDR_BITS_REGF   = 4;
    localparam int unsigned WRITE_PORTS_REGF = 4;
    localparam int unsigned DATA_W           = NSIG + 1;
    localparam int unsigned NREGS            = 1 << ADDR_BITS_REGF;

    typedef logic [WRITE_PORTS_REGF-1:0][ADDR_BITS_REGF-1:0] addr_vec_t;
    typedef logic [WRITE_PORTS_REGF-1:0][DATA_W-1:0]         data_vec_t;

    typedef struct packed {
        logic [WRITE_PORTS_REGF-1:0] mask;
        addr_vec_t                   addr;
        data_vec_t                   data;
    } wb_bundle_t;

endpackage

// File: rtl/wb_bundle_sanitize.sv
// Rewrites a bundle so every port sharing an address carries the same data.
// Invalid slots mirror the highest valid slot; on conflicts the highest lane wins.
module wb_bundle_sanitize
    import regfile_writeback_pkg::*;
(
    input  wb_bundle_t bundle,
    output addr_vec_t  addr,
    output data_vec_t  data
);

    logic [ADDR_BITS_REGF-1:0] h_addr;
    logic [DATA_W-1:0]         h_data;

    // Locate the highest valid slot, then resolve each port against higher lanes.
    always_comb begin
        h_addr = '0;
        h_data = '0;
        addr   = '0;
        data   = '0;
        for (int i = 0; i < int'(WRITE_PORTS_REGF); i++) begin
            if (bundle.mask[i]) begin
                h_addr = bundle.addr[i];
                h_data = bundle.data[i];
            end
        end
        for (int i = 0; i < int'(WRITE_PORTS_REGF); i++) begin
            addr[i] = h_addr;
            data[i] = h_data;
            if (bundle.mask[i]) begin
                addr[i] = bundle.addr[i];
                data[i] = bundle.data[i];
                for (int j = 0; j < int'(WRITE_PORTS_REGF); j++) begin
                    if (j > i && bundle.mask[j] && bundle.addr[j] == bundle.addr[i]) begin
                        data[i] = bundle.data[j];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// Write-side master for the SIMD register file: queues result bundles and
// drains one sanitized bundle per cycle onto the regfile write ports.
module regfile_writeback
    import regfile_writeback_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic                                             in_valid,
    output logic                                             in_ready,
    input  logic [WRITE_PORTS_REGF-1:0]                      in_mask,
    input  logic [WRITE_PORTS_REGF-1:0][ADDR_BITS_REGF-1:0]  in_addr,
    input  logic [WRITE_PORTS_REGF-1:0][DATA_W-1:0]          in_data,
    input  logic                                             stall,
    output logic [WRITE_PORTS_REGF-1:0][ADDR_BITS_REGF-1:0]  w_addr,
    output logic [WRITE_PORTS_REGF-1:0][DATA_W-1:0]          w_data,
    output logic                                             wr_en,
    output logic [NREGS-1:0]                                 busy,
    output logic [$clog2(DEPTH+1)-1:0]                       count,
    output logic                                             idle
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    wb_bundle_t       mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [PTR_W-1:0] idx;
    logic             push;
    logic             pop;
    wb_bundle_t       in_bundle;
    wb_bundle_t       head;
    addr_vec_t        san_addr;
    data_vec_t        san_data;

    // Full is judged on the pre-pop count, so there is no push-through when full.
    assign in_ready  = rst_n && (count != CNT_W'(DEPTH));
    assign push      = in_valid && in_ready && (|in_mask);
    assign pop       = (count != '0) && !stall;
    assign in_bundle = '{mask: in_mask, addr: in_addr, data: in_data};
    assign head      = mem[rptr];
    assign idle      = (count == '0) && !wr_en;

    wb_bundle_sanitize u_sanitize (
        .bundle (head),
        .addr   (san_addr),
        .data   (san_data)
    );

    // Queue storage; contents are only meaningful below count, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= in_bundle;
        end
    end

    // Pointers, occupancy and the registered write port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
            wr_en  <= 1'b0;
            w_addr <= '0;
            w_data <= '0;
        end else begin
            wr_en <= pop;
            if (push) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr   <= rptr + PTR_W'(1);
                w_addr <= san_addr;
                w_data <= san_data;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Pending-write map: valid slots of every queued entry plus the live output register.
    always_comb begin
        busy = '0;
        idx  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < count) begin
                idx = rptr + PTR_W'(i);
                for (int s = 0; s < int'(WRITE_PORTS_REGF); s++) begin
                    if (mem[idx].mask[s]) begin
                        busy[mem[idx].addr[s]] = 1'b1;
                    end
                end
            end
        end
        if (wr_en) begin
            for (int s = 0; s < int'(WRITE_PORTS_REGF); s++) begin
                busy[w_addr[s]] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_writeback.sv
// Scoreboard bench for regfile_writeback with a behavioural regfile stand-in.
module tb_regfile_writeback;
    import regfile_writeback_pkg::*;

    localparam int DEPTH = 4;
    localparam int WP    = int'(WRITE_PORTS_REGF);
    localparam int NR    = int'(NREGS);

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid;
    logic in_ready;
    logic stall;
    wb_bundle_t drv;
    addr_vec_t w_addr;
    data_vec_t w_data;
    logic wr_en;
    logic [NREGS-1:0] busy;
    logic [$clog2(DEPTH+1)-1:0] count;
    logic idle;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    bit started = 1'b0;
    bit rand_stall = 1'b0;

    // Reference model state
    wb_bundle_t pending[$];
    wb_bundle_t out_q[$];
    wb_bundle_t cur;
    bit exp_wr_en = 1'b0;
    bit pop_e;
    bit ready_e;

    logic [DATA_W-1:0] rf     [NR];
    logic [DATA_W-1:0] ref_rf [NR];

    regfile_writeback #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_mask  (drv.mask),
        .in_addr  (drv.addr),
        .in_data  (drv.data),
        .stall    (stall),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .wr_en    (wr_en),
        .busy     (busy),
        .count    (count),
        .idle     (idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected port image: each register gets the last valid lane's value;
    // unused lanes repeat the highest valid lane's register.
    function automatic void exp_ports(input wb_bundle_t b, output addr_vec_t a, output data_vec_t d);
        logic [DATA_W-1:0] last [NR];
        logic [ADDR_BITS_REGF-1:0] ai;
        int h = 0;
        for (int r = 0; r < NR; r++) last[r] = '0;
        for (int i = 0; i < WP; i++) begin
            if (b.mask[i]) begin
                last[b.addr[i]] = b.data[i];
                h = i;
            end
        end
        for (int i = 0; i < WP; i++) begin
            ai = b.mask[i] ? b.addr[i] : b.addr[h];
            a[i] = ai;
            d[i] = last[ai];
        end
    endfunction

    function automatic logic [NREGS-1:0] bundle_regs(input wb_bundle_t b);
        logic [NREGS-1:0] r = '0;
        for (int i = 0; i < WP; i++) if (b.mask[i]) r[b.addr[i]] = 1'b1;
        return r;
    endfunction

    function automatic wb_bundle_t mk(input logic [3:0] m, input int a0, input int a1, input int a2,
                                      input int a3, input int d0, input int d1, input int d2, input int d3);
        wb_bundle_t r;
        r.mask = m;
        r.addr[0] = ADDR_BITS_REGF'(a0); r.addr[1] = ADDR_BITS_REGF'(a1);
        r.addr[2] = ADDR_BITS_REGF'(a2); r.addr[3] = ADDR_BITS_REGF'(a3);
        r.data[0] = DATA_W'(d0); r.data[1] = DATA_W'(d1);
        r.data[2] = DATA_W'(d2); r.data[3] = DATA_W'(d3);
        return r;
    endfunction

    function automatic wb_bundle_t rnd(input bit narrow);
        wb_bundle_t r;
        r.mask = ($urandom_range(0, 7) == 0) ? '0 : WRITE_PORTS_REGF'($urandom_range(1, 15));
        for (int i = 0; i < WP; i++) begin
            r.addr[i] = ADDR_BITS_REGF'($urandom_range(0, narrow ? 3 : 15));
            r.data[i] = DATA_W'($urandom);
        end
        return r;
    endfunction

    // Model: queue of accepted bundles, one popped per unstalled cycle.
    always @(posedge clk) begin
        ready_e = rst_n && (pending.size() != DEPTH);
        if (!rst_n) begin
            pending.delete();
            exp_wr_en = 1'b0;
            started = 1'b1;
        end else begin
            pop_e = (pending.size() > 0) && !stall;
            if (pop_e) begin
                cur = pending.pop_front();
                out_q.push_back(cur);
            end
            exp_wr_en = pop_e;
            if (in_valid && ready_e && (|drv.mask)) pending.push_back(drv);
        end
    end

    // Monitor: status checks every cycle, scoreboard pop and regfile commit on wr_en.
    always @(negedge clk) begin
        logic [NREGS-1:0] exp_busy;
        wb_bundle_t b;
        addr_vec_t ea;
        data_vec_t ed;
        #1;
        if (started) begin
            exp_busy = exp_wr_en ? bundle_regs(cur) : '0;
            foreach (pending[i]) exp_busy |= bundle_regs(pending[i]);
            check("wr_en", 64'(wr_en), 64'(exp_wr_en));
            check("busy", 64'(busy), 64'(exp_busy));
            check("count", 64'(count), 64'(pending.size()));
            check("idle", 64'(idle), 64'((pending.size() == 0) && !exp_wr_en));
            check("in_ready", 64'(in_ready), 64'(rst_n && (pending.size() != DEPTH)));
            if (wr_en === 1'b1) begin
                pulses++;
                for (int p = 0; p < WP; p++) rf[w_addr[p]] = w_data[p];
                if (out_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_wr_en: got wr_en=1 expected no pending output at %0t", $time);
                end else begin
                    b = out_q.pop_front();
                    exp_ports(b, ea, ed);
                    check("w_addr", 64'(w_addr), 64'(ea));
                    check("w_data", 64'(w_data), 64'(ed));
                    for (int i = 0; i < WP; i++) if (b.mask[i]) ref_rf[b.addr[i]] = b.data[i];
                end
            end
        end
    end

    task automatic preload();
        for (int r = 0; r < NR; r++) begin
            rf[r] = DATA_W'(99);
            ref_rf[r] = DATA_W'(99);
        end
    endtask

    // Offer a bundle from a negedge until accepted; n = posedges taken.
    task automatic send(input wb_bundle_t b, output int n);
        logic rdy;
        drv = b;
        in_valid = 1'b1;
        n = 0;
        while (1) begin
            rdy = in_ready;
            @(posedge clk);
            n++;
            if (rdy) break;
            if (n >= 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: got no in_ready in %0d cycles expected acceptance", n);
                break;
            end
            @(negedge clk);
            if (rand_stall) stall = ($urandom_range(0, 3) == 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        stall = 1'b0;
        rand_stall = 1'b0;
        while ((pending.size() != 0 || out_q.size() != 0 || exp_wr_en) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", pending.size());
        end
        repeat (2) @(negedge clk);
        #2;
    endtask

    initial begin
        int n;
        int p;
        wb_bundle_t b;

        // Reset with a full bundle offered
        preload();
        rst_n = 1'b0;
        stall = 1'b0;
        in_valid = 1'b1;
        drv = mk(4'b1111, 1, 2, 3, 4, 5, 6, 7, 8);
        repeat (2) @(negedge clk);
        #2;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_idle", 64'(idle), 64'd1);
        check("rst_count", 64'(count), 64'd0);
        check("rst_rf1", 64'(rf[1]), 64'd99);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);

        // Full bundle into empty queue
        p = pulses;
        send(mk(4'b1111, 1, 2, 3, 4, 10, 20, 30, 40), n);
        drain();
        check("t2_pulses", 64'(pulses - p), 64'd1);
        check("t2_r1", 64'(rf[1]), 64'd10);
        check("t2_r2", 64'(rf[2]), 64'd20);
        check("t2_r3", 64'(rf[3]), 64'd30);
        check("t2_r4", 64'(rf[4]), 64'd40);

        // Sparse mask, then an empty-mask bundle
        send(mk(4'b0101, 7, 0, 9, 0, 70, 0, 90, 0), n);
        drain();
        check("t3_r7", 64'(rf[7]), 64'd70);
        check("t3_r9", 64'(rf[9]), 64'd90);
        check("t3_r0", 64'(rf[0]), 64'd99);
        p = pulses;
        send(mk(4'b0000, 1, 1, 1, 1, 5, 5, 5, 5), n);
        check("t3_empty_accept", 64'(n), 64'd1);
        drain();
        check("t3_empty_pulses", 64'(pulses - p), 64'd0);

        // Address conflict, highest lane wins
        send(mk(4'b1111, 5, 5, 6, 5, 1, 2, 3, 4), n);
        drain();
        check("t4_r5", 64'(rf[5]), 64'd4);
        check("t4_r6", 64'(rf[6]), 64'd3);

        // Fill while stalled, then release
        p = pulses;
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b = rnd(1'b0);
            b.mask = 4'b1111;
            send(b, n);
        end
        #2;
        check("t5_count_full", 64'(count), 64'd4);
        check("t5_ready_full", 64'(in_ready), 64'd0);
        stall = 1'b0;
        b = rnd(1'b0);
        b.mask = 4'b0011;
        send(b, n);
        check("t5_e_wait", 64'(n), 64'd2);
        drain();
        check("t5_pulses", 64'(pulses - p), 64'd5);

        // Reset discards queued bundles
        preload();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b = rnd(1'b0);
            b.mask = 4'b1111;
            send(b, n);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;
        p = pulses;
        repeat (5) @(negedge clk);
        #2;
        check("t6_count", 64'(count), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_pulses", 64'(pulses - p), 64'd0);
        for (int r = 0; r < NR; r++) check("t6_rf", 64'(rf[r]), 64'd99);

        // Randomized traffic with random stalls
        for (int i = 0; i < 300; i++) begin
            rand_stall = 1'b1;
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                stall = ($urandom_range(0, 3) == 0);
            end
            send(rnd(i[0]), n);
        end
        drain();
        for (int r = 0; r < NR; r++) check("rand_rf", 64'(rf[r]), 64'(ref_rf[r]));
        check("out_q_empty", 64'(out_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
